// File: rtl/fixed_pkg.sv
// Shared types, default widths and saturation helpers for the fixed-point MAC datapath.
package fixed_pkg;

  localparam int unsigned DefWI1 = 5;
  localparam int unsigned DefWF1 = 11;
  localparam int unsigned DefWI2 = 5;
  localparam int unsigned DefWF2 = 11;
  localparam int unsigned DefWIA = 12;
  localparam int unsigned DefWIO = 6;
  localparam int unsigned DefWFO = 11;

  localparam int unsigned ProdW = DefWI1 + DefWF1 + DefWI2 + DefWF2;
  localparam int unsigned AccW  = DefWIA + DefWF1 + DefWF2;
  localparam int unsigned OutW  = DefWIO + DefWFO;

  typedef enum logic [1:0] {
    StAcc,
    StFlush,
    StOut
  } state_e;

  // Two's-complement bounds for a w-bit signed value, w <= 63.
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fixed_mac_frame_if.sv
// Operand stream in, result stream out; slave is the MAC engine, master the neighbouring logic.
interface fixed_mac_frame_if #(
  parameter int unsigned WA = 16,
  parameter int unsigned WB = 16,
  parameter int unsigned WO = 17
);

  logic signed [WA-1:0] s_a;
  logic signed [WB-1:0] s_b;
  logic                 s_last;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [WO-1:0] m_result;
  logic                 m_sat;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    output s_a, s_b, s_last, s_valid, m_ready,
    input  s_ready, m_result, m_sat, m_valid
  );

  modport slave (
    input  s_a, s_b, s_last, s_valid, m_ready,
    output s_ready, m_result, m_sat, m_valid
  );

endinterface

// File: rtl/fixed_round_sat.sv
// Round half-up, floor and clamp an accumulator-format sum down to WIO.WFO; flags any clamp.
module fixed_round_sat
  import fixed_pkg::*;
#(
  parameter int unsigned WIA = DefWIA,
  parameter int unsigned WF  = DefWF1 + DefWF2,
  parameter int unsigned WIO = DefWIO,
  parameter int unsigned WFO = DefWFO
) (
  input  logic signed [WIA+WF-1:0]  sum,
  output logic signed [WIO+WFO-1:0] result,
  output logic                      ovf
);

  localparam int unsigned AW = WIA + WF;
  localparam int unsigned OW = WIO + WFO;
  localparam int unsigned SH = WF - WFO;

  localparam logic signed [AW:0] OMax = (AW + 1)'(sat_max(OW));
  localparam logic signed [AW:0] OMin = (AW + 1)'(sat_min(OW));

  // One guard bit so the rounding increment can never wrap.
  logic signed [AW:0] rnd;
  logic signed [AW:0] shifted;

  if (SH > 0) begin : g_round
    localparam logic [AW:0] Half = {{AW{1'b0}}, 1'b1} << (SH - 1);
    assign rnd = {sum[AW-1], sum} + Half;
  end else begin : g_no_round
    assign rnd = {sum[AW-1], sum};
  end

  assign shifted = rnd >>> SH;

  always_comb begin
    ovf    = 1'b0;
    result = shifted[OW-1:0];
    if (shifted > OMax) begin
      ovf    = 1'b1;
      result = OMax[OW-1:0];
    end else if (shifted < OMin) begin
      ovf    = 1'b1;
      result = OMin[OW-1:0];
    end
  end

endmodule

// File: rtl/fixed_mac_frame.sv
// Framed signed multiply-accumulate: pipelined product, saturating accumulator, rounded result.
module fixed_mac_frame
  import fixed_pkg::*;
#(
  parameter int unsigned WI1 = DefWI1,
  parameter int unsigned WF1 = DefWF1,
  parameter int unsigned WI2 = DefWI2,
  parameter int unsigned WF2 = DefWF2,
  parameter int unsigned WIA = DefWIA,
  parameter int unsigned WIO = DefWIO,
  parameter int unsigned WFO = DefWFO
) (
  input logic              clk,
  input logic              reset,
  fixed_mac_frame_if.slave bus
);

  localparam int unsigned FW = WF1 + WF2;
  localparam int unsigned PW = WI1 + WI2 + FW;
  localparam int unsigned CW = WIA + FW;
  localparam int unsigned OW = WIO + WFO;

  localparam logic signed [CW-1:0] AccMax = CW'(sat_max(CW));
  localparam logic signed [CW-1:0] AccMin = CW'(sat_min(CW));

  state_e state_q, state_d;

  logic signed [PW-1:0] mul;
  logic signed [PW-1:0] prod_q;
  logic                 prod_vld_q;
  logic                 accept;

  logic signed [CW-1:0] prod_ext;
  logic signed [CW:0]   sum_wide;
  logic signed [CW-1:0] acc_sum;
  logic                 add_sat;
  logic signed [CW-1:0] acc_q, acc_d;
  logic                 sticky_q, sticky_d;

  logic signed [OW-1:0] rnd_res;
  logic                 rnd_ovf;
  logic signed [OW-1:0] res_q;
  logic                 sat_q;

  assign bus.s_ready  = reset && (state_q == StAcc);
  assign bus.m_valid  = (state_q == StOut);
  assign bus.m_result = res_q;
  assign bus.m_sat    = sat_q;

  assign accept = bus.s_valid && bus.s_ready;
  assign mul    = PW'(bus.s_a) * PW'(bus.s_b);

  // Stage 1: full-precision product.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      prod_vld_q <= accept;
      if (accept) begin
        prod_q <= mul;
      end
    end
  end

  // Stage 2: saturating add, one extra bit to detect overflow.
  assign prod_ext = CW'(prod_q);
  assign sum_wide = {acc_q[CW-1], acc_q} + {prod_ext[CW-1], prod_ext};
  assign add_sat  = sum_wide[CW] ^ sum_wide[CW-1];
  assign acc_sum  = add_sat ? (sum_wide[CW] ? AccMin : AccMax) : sum_wide[CW-1:0];

  fixed_round_sat #(
    .WIA (WIA),
    .WF  (FW),
    .WIO (WIO),
    .WFO (WFO)
  ) u_round_sat (
    .sum    (acc_sum),
    .result (rnd_res),
    .ovf    (rnd_ovf)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sticky_d = sticky_q;
    if (prod_vld_q) begin
      acc_d    = acc_sum;
      sticky_d = sticky_q | add_sat;
    end
    unique case (state_q)
      StAcc: begin
        if (bus.s_valid && bus.s_last) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        // The final product folds straight into the result; clear for the next frame.
        state_d  = StOut;
        acc_d    = '0;
        sticky_d = 1'b0;
      end
      StOut: begin
        if (bus.m_ready) begin
          state_d = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StAcc;
      acc_q    <= '0;
      sticky_q <= 1'b0;
      res_q    <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
      if (state_q == StFlush) begin
        res_q <= rnd_res;
        sat_q <= sticky_q | add_sat | rnd_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fixed_mac_frame.sv
// Scoreboard bench for fixed_mac_frame: directed frames, backpressure, reset abort, random frames.
module tb_fixed_mac_frame;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fixed_mac_frame_if #(.WA(16), .WB(16), .WO(17)) bus ();

  fixed_mac_frame dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int n_pushed = 0;
  int n_results = 0;
  logic [17:0] exp_q[$];
  logic [15:0] fa[32];
  logic [15:0] fb[32];
  bit rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: Q10.22 products into a Q12.22 clamped accumulator, then Q6.11 round/clamp.
  function automatic logic [17:0] model(input int n);
    longint acc = 0;
    longint p;
    longint r;
    longint amax = (longint'(1) <<< 33) - 1;
    longint amin = -(longint'(1) <<< 33);
    bit st = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = longint'($signed(fa[i])) * longint'($signed(fb[i]));
      acc = acc + p;
      if (acc > amax) begin acc = amax; st = 1'b1; end
      else if (acc < amin) begin acc = amin; st = 1'b1; end
    end
    r = (acc + 1024) >>> 11;
    if (r > 65535) begin r = 65535; st = 1'b1; end
    else if (r < -65536) begin r = -65536; st = 1'b1; end
    return {st, r[16:0]};
  endfunction

  task automatic push_exp(input int n);
    exp_q.push_back(model(n));
    n_pushed++;
  endtask

  task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic last);
    int t = 0;
    @(negedge clk);
    bus.s_a = a;
    bus.s_b = b;
    bus.s_last = last;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.s_ready) check("accept_timeout", 64'(bus.s_ready), 1);
    @(posedge clk);
  endtask

  task automatic send_frame(input int n);
    push_exp(n);
    for (int i = 0; i < n; i++) send_beat(fa[i], fb[i], i == n - 1);
  endtask

  task automatic drop_and_drain(input string tag);
    int t = 0;
    @(negedge clk);
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset && bus.m_valid && bus.m_ready) begin : mon
      logic [17:0] e;
      if (exp_q.size() == 0) begin
        check("unexpected_result", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("result", 64'($unsigned(bus.m_result)), 64'(e[16:0]));
        check("sat", 64'(bus.m_sat), 64'(e[17]));
      end
      n_results++;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 bus.m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int t;
    bus.s_a = '0;
    bus.s_b = '0;
    bus.s_last = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(bus.s_ready), 0);
    check("rst_m_valid", 64'(bus.m_valid), 0);
    check("rst_m_result", 64'($unsigned(bus.m_result)), 0);
    check("rst_m_sat", 64'(bus.m_sat), 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_s_ready", 64'(bus.s_ready), 1);

    // 3-beat frame: 1.5*2 + 1*1 - 0.5*1 = 3.5, with latency check.
    fa[0] = 16'h0C00; fb[0] = 16'h1000;
    fa[1] = 16'h0800; fb[1] = 16'h0800;
    fa[2] = 16'hFC00; fb[2] = 16'h0800;
    check("model_3beat", 64'(model(3)), 64'({1'b0, 17'h01C00}));
    send_frame(3);
    @(negedge clk);
    bus.s_valid = 1'b0;
    check("lat_flush_m_valid", 64'(bus.m_valid), 0);
    @(negedge clk);
    check("lat_out_m_valid", 64'(bus.m_valid), 1);
    check("lat_result", 64'($unsigned(bus.m_result)), 64'(17'h01C00));
    drop_and_drain("drain_3beat");

    // Output overflow then a clean frame.
    fa[0] = 16'h7800; fb[0] = 16'h7800;
    send_frame(1);
    drop_and_drain("drain_ovf");
    fa[0] = 16'h0800; fb[0] = 16'h0800;
    send_frame(1);
    drop_and_drain("drain_after_ovf");

    // Rounding at half an output LSB.
    fa[0] = 16'h0001; fb[0] = 16'h0400;
    send_frame(1);
    drop_and_drain("drain_rnd_pos");
    fa[0] = 16'hFFFF; fb[0] = 16'h0400;
    send_frame(1);
    drop_and_drain("drain_rnd_neg");

    // Backpressure: 2*3 = 6.0 held while the next beat waits.
    @(posedge clk);
    #1 bus.m_ready = 1'b0;
    fa[0] = 16'h1000; fb[0] = 16'h1800;
    send_frame(1);
    @(negedge clk);
    bus.s_a = 16'h0800; bus.s_b = 16'h0800; bus.s_last = 1'b1; bus.s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_m_valid", 64'(bus.m_valid), 1);
      check("bp_m_result", 64'($unsigned(bus.m_result)), 64'(17'h03000));
      check("bp_m_sat", 64'(bus.m_sat), 0);
      check("bp_s_ready", 64'(bus.s_ready), 0);
    end
    check("bp_no_result", n_results, n_pushed - 1);
    fa[0] = 16'h0800; fb[0] = 16'h0800;
    push_exp(1);
    @(posedge clk);
    #1 bus.m_ready = 1'b1;
    send_beat(16'h0800, 16'h0800, 1'b1);
    drop_and_drain("drain_bp");

    // Reset mid-frame discards the partial sum.
    send_beat(16'h0800, 16'h0800, 1'b0);
    send_beat(16'h1000, 16'h1000, 1'b0);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_s_ready", 64'(bus.s_ready), 0);
    check("mid_rst_m_valid", 64'(bus.m_valid), 0);
    check("mid_rst_m_result", 64'($unsigned(bus.m_result)), 0);
    check("mid_rst_m_sat", 64'(bus.m_sat), 0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    fa[0] = 16'h0800; fb[0] = 16'h0800;
    send_frame(1);
    drop_and_drain("drain_after_rst");

    // Random back-to-back frames with random result stalls.
    rand_ready = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      int n;
      n = $urandom_range(1, 16);
      for (int i = 0; i < n; i++) begin
        fa[i] = rand_op();
        fb[i] = rand_op();
      end
      send_frame(n);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2 bus.m_ready = 1'b1;
    drop_and_drain("drain_random");
    t = 0;
    while (t < 5) begin
      @(negedge clk);
      t++;
    end
    check("result_count", n_results, n_pushed);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
